muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, parametrised in operand width, owning the architectural HI/LO register pair. It sits beside the combinational ALU in the execute stage and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO. It computes one operation at a time over a fixed number of cycles, using a start/busy/done handshake. The pipeline stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Iteration counter must hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used both for magnitude extraction
// of signed operands and for sign correction of results.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// CALC  | one shift-add / shift-subtract step per cycle, WIDTH steps
// FIX   | sign correction, HI/LO write, done pulse on the following cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               accept, step, finish;
  logic [CNT_W-1:0]   cnt_q;

  logic               is_div_q, sign_a_q, sign_b_q, dz_pend_q;
  logic [WIDTH-1:0]   mb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  // Operand decode and magnitude extraction
  op_e              op_in;
  logic             is_div_in, signed_in, sign_a_in, sign_b_in;
  logic [WIDTH-1:0] ma, mb;

  assign op_in     = op_e'(op);
  assign is_div_in = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sign_a_in = signed_in & a[WIDTH-1];
  assign sign_b_in = signed_in & b[WIDTH-1];

  muldiv_sign_fix #(.W(WIDTH)) u_fix_a (.neg(sign_a_in), .din(a), .dout(ma));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_b (.neg(sign_b_in), .din(b), .dout(mb));

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Shared WIDTH+1 adder: multiply adds mb, divide adds ~mb+1 (subtract).
  logic [WIDTH-1:0]   acc_hi, acc_lo, div_r_lo, add_x, add_y;
  logic               div_r_top, div_ok;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] acc_step;

  assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo    = acc_q[WIDTH-1:0];
  assign div_r_lo  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign div_r_top = acc_hi[WIDTH-1];
  assign add_x     = is_div_q ? div_r_lo : acc_hi;
  assign add_y     = is_div_q ? ~mb_q : mb_q;
  assign add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, is_div_q};
  // A set top bit of the shifted remainder already guarantees it exceeds mb.
  assign div_ok    = div_r_top | add_sum[WIDTH];

  always_comb begin
    acc_step = acc_q;
    if (is_div_q) begin
      acc_step = {(div_ok ? add_sum[WIDTH-1:0] : div_r_lo), acc_lo[WIDTH-2:0], div_ok};
    end else if (acc_lo[0]) begin
      acc_step = {add_sum, acc_lo[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
  end

  // Result sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .neg (sign_a_q ^ sign_b_q),
    .din (acc_q),
    .dout(prod_fix)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .neg (sign_a_q ^ sign_b_q),
    .din (acc_lo),
    .dout(quo_fix)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg (sign_a_q),
    .din (acc_hi),
    .dout(rem_fix)
  );

  // With a zero divisor the restoring loop leaves the dividend magnitude in
  // the remainder, so HI comes back as a; only LO needs forcing.
  assign res_hi = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (dz_pend_q ? {WIDTH{1'b1}} : quo_fix)
                           : prod_fix[WIDTH-1:0];

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      mb_q      <= '0;
      acc_q     <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      is_div_q  <= is_div_in;
      sign_a_q  <= sign_a_in;
      sign_b_q  <= sign_b_in;
      dz_pend_q <= is_div_in && (b == '0);
      mb_q      <= mb;
      acc_q     <= {{WIDTH{1'b0}}, ma};
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_step;
    end
  end

  // Architectural HI/LO and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
        dz_q <= dz_pend_q;
      end else if ((state_q == IDLE) && !start) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Starts one op, optionally pokes start+hi_we during
  // busy (poke = busy-cycle index, 0 = none), then checks result and timing.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int poke, input logic lwe);
    logic [W-1:0] oh, ol;
    int           bc;
    logic         held;
    oh = hi;
    ol = lo;
    start = 1'b1; op = o; a = x; b = y;
    lo_we = lwe; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0; lo_we = 1'b0; a = '0; b = '0;
    bc   = 0;
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (hi !== oh || lo !== ol) held = 1'b0;
      if (poke != 0) begin
        if (bc == poke) begin
          start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF_0000;
          op = 2'b01; a = 32'd9; b = 32'd9;
        end else begin
          start = 1'b0; hi_we = 1'b0;
        end
      end
    end
    start = 1'b0; hi_we = 1'b0;
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(W + 1));
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".dz"}, 64'(div_by_zero), 64'(edz));
    chk({tag, ".hold"}, 64'(held), 64'd1);
  endtask

  initial begin
    logic quiet;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dz", 64'(div_by_zero), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op("mult_n3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 1'b0);
    run_op("mult_b2b", 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h10, 1'b0, 0, 1'b0);
    run_op("div_n7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("divu_7d2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 0, 1'b0);
    run_op("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op("divu_zero", 2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("dz_hold.dz", 64'(div_by_zero), 64'd1);
    chk("dz_hold.done", 64'(done), 64'd0);
    run_op("multu_2x3", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 0, 1'b0);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("mthi.hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mthi.lo", 64'(lo), 64'd6);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo.hi", 64'(hi), 64'h5A5A_5A5A);
    chk("mthilo.lo", 64'(lo), 64'h5A5A_5A5A);
    @(negedge clk);

    run_op("busy_poke", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 5, 1'b0);
    @(negedge clk);
    chk("no_queue.busy", 64'(busy), 64'd0);
    run_op("lowe_start", 2'b00, 32'd1, 32'd1, 32'h0, 32'd1, 1'b0, 0, 1'b1);
    run_op("div_zero_s", 2'b11, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

    // Reset pulse in the middle of a DIV
    start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.dz", 64'(div_by_zero), 64'd0);
    chk("midrst.hi", 64'(hi), 64'd0);
    chk("midrst.lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("midrst.quiet", 64'(quiet), 64'd1);
    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
